// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - req/ack data-memory bus between mem_access_unit and memory
interface mem_access_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  bus_req;
  logic                  bus_we;
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic [3:0]            bus_be;
  logic [DATA_WIDTH-1:0] bus_wdata;
  logic [DATA_WIDTH-1:0] bus_rdata;
  logic                  bus_ack;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_rdata, bus_ack
  );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - data-memory responder: strobe decode, req/ack bus cycle, load alignment
module mem_access_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  memRead,
  input  logic                  memWrite,
  input  logic                  memIsSigned,
  input  logic [1:0]            memDataSize,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  stall,
  output logic                  err,
  mem_access_unit_if.master     bus
);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_REQ  = 2'b01;
  localparam logic [1:0] S_DONE = 2'b10;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int              WD_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;

  logic [1:0]            state, state_nxt;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [1:0]            lat_size;
  logic                  lat_signed;
  logic                  lat_we;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic [DATA_WIDTH-1:0] cap_data;
  logic                  timed_out;
  logic [WD_W-1:0]       wd_cnt;

  logic req_in, bad_req, accept, in_req, wd_fire;

  assign req_in  = memRead | memWrite;
  assign bad_req = (memRead & memWrite)
                 | (memDataSize == 2'b11)
                 | ((memDataSize == SZ_HALF) & addr[0])
                 | ((memDataSize == SZ_WORD) & (addr[1:0] != 2'b00));
  assign accept  = (state == S_IDLE) & req_in & ~bad_req;
  assign in_req  = (state == S_REQ);
  // An ack on the final watchdog cycle still wins over the timeout.
  assign wd_fire = (TIMEOUT != 0) & in_req & ~bus.bus_ack & (wd_cnt == WD_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_REQ;
      S_REQ:   if (bus.bus_ack || wd_fire) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      lat_addr   <= '0;
      lat_size   <= '0;
      lat_signed <= 1'b0;
      lat_we     <= 1'b0;
      lat_wdata  <= '0;
      cap_data   <= '0;
      timed_out  <= 1'b0;
      wd_cnt     <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        lat_addr   <= addr;
        lat_size   <= memDataSize;
        lat_signed <= memIsSigned;
        lat_we     <= memWrite;
        lat_wdata  <= wdata;
      end
      if (in_req) begin
        wd_cnt    <= wd_cnt + 1'b1;
        timed_out <= wd_fire;
      end else begin
        wd_cnt <= '0;
      end
      if (in_req && bus.bus_ack)
        cap_data <= bus.bus_rdata;
    end
  end

  logic [3:0]            lane_be;
  logic [DATA_WIDTH-1:0] lane_wdata;

  always_comb begin
    lane_be    = 4'b1111;
    lane_wdata = lat_wdata;
    case (lat_size)
      SZ_BYTE: begin
        lane_be    = 4'b0001 << lat_addr[1:0];
        lane_wdata = {4{lat_wdata[7:0]}};
      end
      SZ_HALF: begin
        lane_be    = lat_addr[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{lat_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign bus.bus_req   = in_req;
  assign bus.bus_we    = in_req & lat_we;
  assign bus.bus_addr  = in_req ? {lat_addr[ADDR_WIDTH-1:2], 2'b00} : '0;
  assign bus.bus_be    = in_req ? lane_be : 4'b0000;
  assign bus.bus_wdata = in_req ? lane_wdata : '0;

  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [DATA_WIDTH-1:0] ld_ext;

  always_comb begin
    ld_byte = cap_data[7:0];
    case (lat_addr[1:0])
      2'b01:   ld_byte = cap_data[15:8];
      2'b10:   ld_byte = cap_data[23:16];
      2'b11:   ld_byte = cap_data[31:24];
      default: ld_byte = cap_data[7:0];
    endcase
    ld_half = lat_addr[1] ? cap_data[31:16] : cap_data[15:0];
    case (lat_size)
      SZ_BYTE: ld_ext = {{24{lat_signed & ld_byte[7]}}, ld_byte};
      SZ_HALF: ld_ext = {{16{lat_signed & ld_half[15]}}, ld_half};
      default: ld_ext = cap_data;
    endcase
  end

  assign rdata = ((state == S_DONE) && !lat_we && !timed_out) ? ld_ext : '0;

  // Gated by rst so the combinational outputs are also quiet while reset is held.
  assign stall = rst & (accept | in_req);
  assign err   = rst & (((state == S_IDLE) & req_in & bad_req) | ((state == S_DONE) & timed_out));

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit
module tb_mem_access_unit;
  logic        clk;
  logic        rst;
  logic        memRead, memWrite, memIsSigned;
  logic [1:0]  memDataSize;
  logic [31:0] addr, wdata, rdata;
  logic        stall, err;

  int checks   = 0;
  int failures = 0;

  mem_access_unit_if bus ();

  mem_access_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .memRead     (memRead),
    .memWrite    (memWrite),
    .memIsSigned (memIsSigned),
    .memDataSize (memDataSize),
    .addr        (addr),
    .wdata       (wdata),
    .rdata       (rdata),
    .stall       (stall),
    .err         (err),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    memRead = 0; memWrite = 0; memIsSigned = 0; memDataSize = 2'b00; addr = '0; wdata = '0;
  endtask

  // Runs one access from IDLE; ack_at = index of the REQ cycle carrying the ack, -1 = none.
  task automatic run_access(
    input  logic rd, input logic wr, input logic sg, input logic [1:0] sz,
    input  logic [31:0] a, input logic [31:0] wd, input int ack_at, input logic [31:0] ack_data,
    output logic [3:0] o_be, output logic [31:0] o_addr, output logic [31:0] o_wdata,
    output logic [31:0] o_rdata, output logic o_we,
    output int o_stall, output int o_req, output int o_err, output logic o_done);
    o_be = 0; o_addr = 0; o_wdata = 0; o_rdata = 0; o_we = 0;
    o_stall = 0; o_req = 0; o_err = 0; o_done = 0;
    @(posedge clk); #1;
    memRead = rd; memWrite = wr; memIsSigned = sg; memDataSize = sz; addr = a; wdata = wd;
    #1;
    if (stall) o_stall++;
    if (err) o_err++;
    if (!stall) begin
      clear_inputs();
      @(posedge clk); #1;
      if (bus.bus_req) o_req++;
      if (err) o_err++;
      o_done = 1;
    end else begin
      for (int i = 0; i < 20 && !o_done; i++) begin
        @(posedge clk); #1;
        bus.bus_ack = 0;
        if (err) o_err++;
        if (bus.bus_req) begin
          if (o_req == 0) begin
            o_be = bus.bus_be; o_addr = bus.bus_addr; o_wdata = bus.bus_wdata; o_we = bus.bus_we;
          end
          o_req++;
        end
        if (stall) begin
          o_stall++;
          if (ack_at >= 0 && o_req == ack_at + 1) begin
            bus.bus_ack = 1; bus.bus_rdata = ack_data;
          end
        end else begin
          o_rdata = rdata;
          o_done  = 1;
          clear_inputs();
        end
      end
    end
  endtask

  logic [3:0]  be;
  logic [31:0] ba, bw, rv;
  logic        we, dn;
  int          ns, nr, ne;

  initial begin
    rst = 0; clear_inputs(); bus.bus_ack = 0; bus.bus_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_bus_req", 32'(bus.bus_req), 32'd0);
    rst = 1;

    // lb signed, byte lane 3, ack in third REQ cycle
    run_access(1, 0, 1, 2'b00, 32'h0000_1003, 0, 2, 32'h80FF_FF7F, be, ba, bw, rv, we, ns, nr, ne, dn);
    chk("lb_done", 32'(dn), 32'd1);
    chk("lb_be", 32'(be), 32'h8);
    chk("lb_addr", ba, 32'h0000_1000);
    chk("lb_we", 32'(we), 32'd0);
    chk("lb_rdata", rv, 32'hFFFF_FF80);
    chk("lb_stall_cycles", 32'(ns), 32'd4);
    chk("lb_req_cycles", 32'(nr), 32'd3);
    chk("lb_err", 32'(ne), 32'd0);

    // lhu / lh upper half
    run_access(1, 0, 0, 2'b01, 32'h0000_2002, 0, 0, 32'hBEEF_1234, be, ba, bw, rv, we, ns, nr, ne, dn);
    chk("lhu_be", 32'(be), 32'hC);
    chk("lhu_rdata", rv, 32'h0000_BEEF);
    chk("lhu_stall_cycles", 32'(ns), 32'd2);
    run_access(1, 0, 1, 2'b01, 32'h0000_2002, 0, 0, 32'hBEEF_1234, be, ba, bw, rv, we, ns, nr, ne, dn);
    chk("lh_rdata", rv, 32'hFFFF_BEEF);

    // sb lane 1
    run_access(0, 1, 0, 2'b00, 32'h0000_3001, 32'h0000_00A5, 0, 32'hDEAD_BEEF, be, ba, bw, rv, we, ns, nr, ne, dn);
    chk("sb_we", 32'(we), 32'd1);
    chk("sb_be", 32'(be), 32'h2);
    chk("sb_wdata", bw, 32'hA5A5_A5A5);
    chk("sb_rdata", rv, 32'd0);
    chk("sb_stall_cycles", 32'(ns), 32'd2);

    // sh upper half and sw
    run_access(0, 1, 0, 2'b01, 32'h0000_5002, 32'h1234_5678, 1, 0, be, ba, bw, rv, we, ns, nr, ne, dn);
    chk("sh_be", 32'(be), 32'hC);
    chk("sh_wdata", bw, 32'h5678_5678);
    run_access(0, 1, 0, 2'b10, 32'h0000_6000, 32'hCAFE_F00D, 0, 0, be, ba, bw, rv, we, ns, nr, ne, dn);
    chk("sw_be", 32'(be), 32'hF);
    chk("sw_wdata", bw, 32'hCAFE_F00D);

    // lw ignores memIsSigned; lbu lane 1; lh lower half positive
    run_access(1, 0, 1, 2'b10, 32'h0000_7004, 0, 0, 32'h8765_4321, be, ba, bw, rv, we, ns, nr, ne, dn);
    chk("lw_addr", ba, 32'h0000_7004);
    chk("lw_rdata", rv, 32'h8765_4321);
    run_access(1, 0, 0, 2'b00, 32'h0000_8001, 0, 0, 32'h0000_9A00, be, ba, bw, rv, we, ns, nr, ne, dn);
    chk("lbu_be", 32'(be), 32'h2);
    chk("lbu_rdata", rv, 32'h0000_009A);
    run_access(1, 0, 1, 2'b01, 32'h0000_9000, 0, 0, 32'h8000_7FFF, be, ba, bw, rv, we, ns, nr, ne, dn);
    chk("lh_lo_be", 32'(be), 32'h3);
    chk("lh_lo_rdata", rv, 32'h0000_7FFF);

    // illegal requests: err pulse, no bus cycle, no stall
    run_access(1, 0, 0, 2'b10, 32'h0000_4002, 0, 0, 0, be, ba, bw, rv, we, ns, nr, ne, dn);
    chk("mis_word_err", 32'(ne), 32'd1);
    chk("mis_word_stall", 32'(ns), 32'd0);
    chk("mis_word_req", 32'(nr), 32'd0);
    run_access(1, 0, 0, 2'b11, 32'h0000_4000, 0, 0, 0, be, ba, bw, rv, we, ns, nr, ne, dn);
    chk("size11_err", 32'(ne), 32'd1);
    chk("size11_req", 32'(nr), 32'd0);
    run_access(1, 1, 0, 2'b10, 32'h0000_4000, 0, 0, 0, be, ba, bw, rv, we, ns, nr, ne, dn);
    chk("rdwr_err", 32'(ne), 32'd1);
    chk("rdwr_stall", 32'(ns), 32'd0);
    run_access(1, 0, 0, 2'b01, 32'h0000_4001, 0, 0, 0, be, ba, bw, rv, we, ns, nr, ne, dn);
    chk("mis_half_err", 32'(ne), 32'd1);

    // watchdog expiry with TIMEOUT=4
    run_access(1, 0, 0, 2'b10, 32'h0000_C000, 0, -1, 0, be, ba, bw, rv, we, ns, nr, ne, dn);
    chk("to_done", 32'(dn), 32'd1);
    chk("to_req_cycles", 32'(nr), 32'd4);
    chk("to_err", 32'(ne), 32'd1);
    chk("to_rdata", rv, 32'd0);
    chk("to_stall_cycles", 32'(ns), 32'd5);

    // async reset during REQ, then a stray ack
    @(posedge clk); #1;
    memRead = 1; memDataSize = 2'b10; addr = 32'h0000_A000;
    #1;
    chk("rr_stall_idle", 32'(stall), 32'd1);
    @(posedge clk); #1;
    chk("rr_req_before", 32'(bus.bus_req), 32'd1);
    #2 rst = 0;
    #1;
    chk("rr_req_async", 32'(bus.bus_req), 32'd0);
    chk("rr_stall_async", 32'(stall), 32'd0);
    @(posedge clk); #1;
    clear_inputs();
    rst = 1;
    bus.bus_ack = 1; bus.bus_rdata = 32'h1111_1111;
    @(posedge clk); #1;
    bus.bus_ack = 0;
    chk("late_ack_req", 32'(bus.bus_req), 32'd0);
    chk("late_ack_stall", 32'(stall), 32'd0);
    chk("late_ack_rdata", rdata, 32'd0);
    run_access(1, 0, 0, 2'b10, 32'h0000_B000, 0, 1, 32'h1357_9BDF, be, ba, bw, rv, we, ns, nr, ne, dn);
    chk("post_rst_rdata", rv, 32'h1357_9BDF);
    chk("post_rst_stall", 32'(ns), 32'd3);
    chk("post_rst_err", 32'(ne), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
